// File: rtl/mux_nto1_pipe.sv
// N-to-1 channel multiplexer with a one-deep valid/ready output register.
// Define MUX_NTO1_PIPE_RR_EN to enable the round-robin select mode.
module mux_nto1_pipe #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [WIDTH-1:0] chan_s [NUM_IN];
    logic [SEL_W-1:0] eff_sel_s;
    logic [WIDTH-1:0] sel_data_s;
    logic             sel_err_s;
    logic             in_ready_s;
    logic             xfer_s;

    logic [WIDTH-1:0] out_data_r;
    logic [SEL_W-1:0] out_sel_r;
    logic             out_err_r;
    logic             out_valid_r;

    for (genvar k = 0; k < NUM_IN; k++) begin : g_chan
        assign chan_s[k] = in_data[k*WIDTH +: WIDTH];
    end

    assign in_ready_s = !out_valid_r || out_ready;
    assign xfer_s     = in_valid && in_ready_s;

`ifdef MUX_NTO1_PIPE_RR_EN
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_IN - 1);

    logic [SEL_W-1:0] rr_ptr_r;

    // Round-robin pointer: steps on every round-robin transfer and wraps at the last channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r <= '0;
        end else if (xfer_s && mode) begin
            if (rr_ptr_r == LAST_SEL) begin
                rr_ptr_r <= '0;
            end else begin
                rr_ptr_r <= rr_ptr_r + 1'b1;
            end
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Effective select: pointer in round-robin mode, external select otherwise.
    always_comb begin
        eff_sel_s = sel;
        if (mode) begin
            eff_sel_s = rr_ptr_r;
        end else begin
            eff_sel_s = sel;
        end
    end
`else
    logic unused_mode_s;

    assign unused_mode_s = mode;

    // Effective select: round-robin support is compiled out, so sel always wins.
    always_comb begin
        eff_sel_s = sel;
    end
`endif

    // Channel mux; selects beyond the last channel yield zero data and flag an error.
    always_comb begin
        sel_data_s = '0;
        sel_err_s  = ({{(32-SEL_W){1'b0}}, eff_sel_s} >= 32'(NUM_IN));
        if (sel_err_s) begin
            sel_data_s = '0;
        end else begin
            sel_data_s = chan_s[eff_sel_s];
        end
    end

    // Output register: load on transfer, drop valid on a pop with no refill, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_sel_r   <= '0;
            out_err_r   <= 1'b0;
        end else if (xfer_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= sel_data_s;
            out_sel_r   <= eff_sel_s;
            out_err_r   <= sel_err_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
            out_data_r  <= out_data_r;
            out_sel_r   <= out_sel_r;
            out_err_r   <= out_err_r;
        end else begin
            out_valid_r <= out_valid_r;
            out_data_r  <= out_data_r;
            out_sel_r   <= out_sel_r;
            out_err_r   <= out_err_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_data  = out_data_r;
    assign out_sel   = out_sel_r;
    assign out_err   = out_err_r;
    assign out_valid = out_valid_r;

endmodule

// File: doc/mux_nto1_pipe.md
MUX_NTO1_PIPE -- requirements
Module: mux_nto1_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data width per channel in bits (1..64).
REQ-002 The block SHALL have parameter NUM_IN, default 4, giving the number of input channels (2..16).
REQ-003 The block SHALL have parameter SEL_W, default 2, giving the select width; it SHALL equal clog2(NUM_IN).
REQ-004 The block SHALL use one clock and a synchronous, active-high reset; clock and reset ports are clk and rst.
REQ-005 The block SHALL have port: clk  input  1  clock; all state updates on the rising edge.
REQ-006 The block SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-007 The block SHALL have port: in_data  input  NUM_IN*WIDTH  packed channels; channel k is bits [k*WIDTH +: WIDTH].
REQ-008 The block SHALL have port: sel  input  SEL_W  channel select, used when mode=0.
REQ-009 The block SHALL have port: mode  input  1  0 = external select, 1 = round-robin select.
REQ-010 The block SHALL have port: in_valid  input  1  upstream offers a transfer.
REQ-011 The block SHALL have port: in_ready  output  1  block accepts a transfer this cycle.
REQ-012 The block SHALL have port: out_data  output  WIDTH  registered selected data.
REQ-013 The block SHALL have port: out_sel  output  SEL_W  channel index that produced out_data.
REQ-014 The block SHALL have port: out_err  output  1  out_data came from an out-of-range select.
REQ-015 The block SHALL have port: out_valid  output  1  out_data/out_sel/out_err are valid.
REQ-016 The block SHALL have port: out_ready  input  1  downstream accepts the output.

Function
REQ-017 The effective select SHALL be sel when mode=0, and the internal pointer rr_ptr when mode=1.
REQ-018 Accept condition: in_ready SHALL equal (!out_valid || out_ready), combinationally; a transfer occurs when in_valid && in_ready.
REQ-019 On a transfer, the block SHALL register the data of the selected channel into out_data, the effective select into out_sel, and set out_valid=1; latency is 1 cycle.
REQ-020 When out_valid && out_ready && !(in_valid && in_ready), out_valid SHALL clear the next cycle; out_data and out_sel SHALL hold their values.
REQ-021 While out_valid && !out_ready, out_data, out_sel and out_err SHALL hold stable and in_ready SHALL be 0.
REQ-022 Simultaneous output pop and input push in the same cycle SHALL load the new data, with out_valid remaining 1 and no bubble.
REQ-023 When the effective select is >= NUM_IN (possible only when NUM_IN is not a power of two), out_data SHALL load zero and out_err SHALL load 1; otherwise out_err SHALL load 0.
REQ-024 rr_ptr SHALL increment by 1 on each transfer made with mode=1, and wrap from NUM_IN-1 to 0; it SHALL never take a value >= NUM_IN.
REQ-025 rr_ptr SHALL hold its value on transfers with mode=0 and on cycles without a transfer.
REQ-026 A change of mode between transfers SHALL take effect on the next transfer; no data SHALL be lost or duplicated.

Reset
REQ-027 While rst=1 at a clock edge, the block SHALL set out_valid=0, out_data=0, out_sel=0, out_err=0 and rr_ptr=0.
REQ-028 An assertion of rst while out_valid=1 SHALL discard the held output; in_ready SHALL read 1 in the cycle after reset.
REQ-029 The block SHALL ignore a transfer attempted in a cycle where rst=1.

Configuration
REQ-030 With macro MUX_NTO1_PIPE_RR_EN defined, mode SHALL behave as in REQ-017 and REQ-024..REQ-026.
REQ-031 With MUX_NTO1_PIPE_RR_EN undefined, the rr_ptr logic SHALL be absent, mode SHALL be ignored, and the block SHALL always use sel; the port list SHALL be unchanged.

Verification
REQ-032 Scenario, WIDTH=32/NUM_IN=4: rst, then mode=0, sel=2, ch2=0xDEADBEEF, in_valid=1, out_ready=1 -> next cycle out_valid=1, out_data=0xDEADBEEF, out_sel=2, out_err=0.
REQ-033 Scenario: out_ready=0 with output held, then new in_valid -> in_ready=0 and out_data unchanged for 5 cycles; out_ready=1 -> the new data is loaded in the same cycle as the pop.
REQ-034 Scenario, RR enabled: mode=1, channels k=0x100+k, 6 back-to-back transfers -> out_sel sequence 0,1,2,3,0,1 and out_data 0x100,0x101,0x102,0x103,0x100,0x101.
REQ-035 Scenario, NUM_IN=3/SEL_W=2: mode=0, sel=3, transfer -> out_data=0, out_err=1, out_valid=1.
REQ-036 Scenario: rst pulsed while out_valid=1 and out_ready=0 -> next cycle out_valid=0, rr_ptr=0 (next RR transfer has out_sel=0), in_ready=1.
REQ-037 Scenario, RR macro undefined: mode=1, sel=1, 3 transfers -> out_sel=1 on all three.
